// File: rtl/demux_rr_1an.sv
// ---------------------------------------------------------------------------
// demux_rr_1an
// Parametrised 1-to-N round-robin demultiplexer for the receive path.
// Consecutive valid input words are steered to lanes 0,1,...,NUM_OUT-1 and
// the pointer then wraps. All outputs are registered (one cycle latency).
//
// Ports:
//   clk_2f     in   fast-domain clock, rising edge
//   reset      in   synchronous active-high reset
//   valid_in   in   data_in carries a word this cycle
//   data_in    in   [DATA_W]  input word
//   align      in   force the next word to lane 0
//   data_out   out  [NUM_OUT*DATA_W] lane i at [i*DATA_W +: DATA_W]
//   valid_out  out  [NUM_OUT] per-lane valid (pulse or sticky)
//   lane_sel   out  [SEL_W] lane the next word goes to
//   group_done out  pulse: last lane was written on the previous edge
//   group_cnt  out  [CNT_W] completed groups, wraps
//   align_err  out  pulse: align seen while pointer was not at lane 0
// ---------------------------------------------------------------------------
module demux_rr_1an #(
  parameter int DATA_W     = 4,
  parameter int NUM_OUT    = 2,
  parameter int HOLD_LAST  = 1,
  parameter int VALID_MODE = 1,
  parameter int CNT_W      = 8,
  localparam int SEL_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                      clk_2f,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      align,
  output logic [NUM_OUT*DATA_W-1:0] data_out,
  output logic [NUM_OUT-1:0]        valid_out,
  output logic [SEL_W-1:0]          lane_sel,
  output logic                      group_done,
  output logic [CNT_W-1:0]          group_cnt,
  output logic                      align_err
);

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(NUM_OUT - 1);

  logic [SEL_W-1:0]  r_lane_sel;
  logic              r_group_done;
  logic [CNT_W-1:0]  r_group_cnt;
  logic              r_align_err;
  logic [DATA_W-1:0] r_lane_data  [NUM_OUT];
  logic              r_lane_valid [NUM_OUT];

  logic [SEL_W-1:0]  w_ptr;
  logic              w_last;

  // Effective pointer: align overrides the stored pointer for this word.
  assign w_ptr  = align ? '0 : r_lane_sel;
  assign w_last = (w_ptr == LAST_LANE);

  // Pointer, group tracking and alignment error.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_lane_sel   <= '0;
      r_group_done <= 1'b0;
      r_group_cnt  <= '0;
      r_align_err  <= 1'b0;
    end else begin
      // Flag realignment that breaks a partially filled group.
      r_align_err <= align && (r_lane_sel != '0);
      if (valid_in) begin
        r_lane_sel   <= w_last ? '0 : (w_ptr + SEL_W'(1));
        r_group_done <= w_last;
        if (w_last) begin
          r_group_cnt <= r_group_cnt + CNT_W'(1);
        end
      end else begin
        r_lane_sel   <= w_ptr;
        r_group_done <= 1'b0;
      end
    end
  end

  // One register slice per lane; only the lane matching w_ptr is written.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_lane
      logic w_wr;
      assign w_wr = valid_in && (w_ptr == SEL_W'(gi));

      always_ff @(posedge clk_2f) begin
        if (reset) begin
          r_lane_data[gi]  <= '0;
          r_lane_valid[gi] <= 1'b0;
        end else if (w_wr) begin
          r_lane_data[gi]  <= data_in;
          r_lane_valid[gi] <= 1'b1;
        end else begin
          r_lane_data[gi]  <= (HOLD_LAST != 0) ? r_lane_data[gi] : '0;
          r_lane_valid[gi] <= (VALID_MODE != 0) ? r_lane_valid[gi] : 1'b0;
        end
      end

      assign data_out[gi*DATA_W +: DATA_W] = r_lane_data[gi];
      assign valid_out[gi]                 = r_lane_valid[gi];
    end
  endgenerate

  assign lane_sel   = r_lane_sel;
  assign group_done = r_group_done;
  assign group_cnt  = r_group_cnt;
  assign align_err  = r_align_err;

endmodule

// File: tb/tb_demux_rr_1an.sv
// ---------------------------------------------------------------------------
// tb_demux_rr_1an
// Four demux instances with different parameter sets share one stimulus
// stream. A reference model tracks, per instance, how many words have
// entered the current group and derives every output from that count.
//   inst 0: NUM_OUT=2, CNT_W=2 (counter wrap), hold/sticky
//   inst 1: NUM_OUT=4, HOLD_LAST=0, VALID_MODE=0 (pulse lanes)
//   inst 2: NUM_OUT=3, defaults
//   inst 3: NUM_OUT=1
// ---------------------------------------------------------------------------
module tb_demux_rr_1an;

  logic       clk;
  logic       rst;
  logic       vin;
  logic [3:0] din;
  logic       aln;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT outputs
  logic [7:0]  d0;  logic [1:0] v0; logic [0:0] s0; logic g0; logic [1:0] c0; logic e0;
  logic [15:0] d1;  logic [3:0] v1; logic [1:0] s1; logic g1; logic [7:0] c1; logic e1;
  logic [11:0] d2;  logic [2:0] v2; logic [1:0] s2; logic g2; logic [7:0] c2; logic e2;
  logic [3:0]  d3;  logic [0:0] v3; logic [0:0] s3; logic g3; logic [7:0] c3; logic e3;

  demux_rr_1an #(.DATA_W(4), .NUM_OUT(2), .HOLD_LAST(1), .VALID_MODE(1), .CNT_W(2)) u_dut0 (
    .clk_2f(clk), .reset(rst), .valid_in(vin), .data_in(din), .align(aln),
    .data_out(d0), .valid_out(v0), .lane_sel(s0), .group_done(g0),
    .group_cnt(c0), .align_err(e0));

  demux_rr_1an #(.DATA_W(4), .NUM_OUT(4), .HOLD_LAST(0), .VALID_MODE(0), .CNT_W(8)) u_dut1 (
    .clk_2f(clk), .reset(rst), .valid_in(vin), .data_in(din), .align(aln),
    .data_out(d1), .valid_out(v1), .lane_sel(s1), .group_done(g1),
    .group_cnt(c1), .align_err(e1));

  demux_rr_1an #(.DATA_W(4), .NUM_OUT(3), .HOLD_LAST(1), .VALID_MODE(1), .CNT_W(8)) u_dut2 (
    .clk_2f(clk), .reset(rst), .valid_in(vin), .data_in(din), .align(aln),
    .data_out(d2), .valid_out(v2), .lane_sel(s2), .group_done(g2),
    .group_cnt(c2), .align_err(e2));

  demux_rr_1an #(.DATA_W(4), .NUM_OUT(1), .HOLD_LAST(1), .VALID_MODE(1), .CNT_W(8)) u_dut3 (
    .clk_2f(clk), .reset(rst), .valid_in(vin), .data_in(din), .align(aln),
    .data_out(d3), .valid_out(v3), .lane_sel(s3), .group_done(g3),
    .group_cnt(c3), .align_err(e3));

  // Expected outputs for all four instances after one clock edge.
  typedef struct packed {
    logic [3:0][15:0] data;
    logic [3:0][3:0]  valid;
    logic [3:0][1:0]  sel;
    logic [3:0]       gd;
    logic [3:0][7:0]  cnt;
    logic [3:0]       ae;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int step_no = 0;

  // Per-instance configuration
  int p_n  [4] = '{2, 4, 3, 1};
  int p_hl [4] = '{1, 0, 1, 1};
  int p_vm [4] = '{1, 0, 1, 1};
  int p_cw [4] = '{2, 8, 8, 8};

  // Model state: words already placed in the current group, groups
  // completed, and the visible lane contents.
  int   m_pos    [4];
  int   m_groups [4];
  logic [3:0] m_lane [4][4];
  logic m_val [4][4];
  logic m_gd [4];
  logic m_ae [4];

  task automatic model_step(input logic r, input logic v, input logic [3:0] d,
                            input logic a, output exp_t e);
    e = '0;
    for (int k = 0; k < 4; k++) begin
      if (r) begin
        m_pos[k] = 0;
        m_groups[k] = 0;
        m_gd[k] = 1'b0;
        m_ae[k] = 1'b0;
        for (int l = 0; l < 4; l++) begin
          m_lane[k][l] = 4'h0;
          m_val[k][l]  = 1'b0;
        end
      end else begin
        m_ae[k] = a && (m_pos[k] != 0);
        if (a) m_pos[k] = 0;
        for (int l = 0; l < p_n[k]; l++) begin
          if (v && l == m_pos[k]) begin
            m_lane[k][l] = d;
            m_val[k][l]  = 1'b1;
          end else begin
            if (p_hl[k] == 0) m_lane[k][l] = 4'h0;
            if (p_vm[k] == 0) m_val[k][l]  = 1'b0;
          end
        end
        if (v) begin
          m_pos[k] = m_pos[k] + 1;
          if (m_pos[k] == p_n[k]) begin
            m_pos[k] = 0;
            m_groups[k] = m_groups[k] + 1;
            m_gd[k] = 1'b1;
          end else begin
            m_gd[k] = 1'b0;
          end
        end else begin
          m_gd[k] = 1'b0;
        end
      end
      for (int l = 0; l < p_n[k]; l++) begin
        e.data[k][l*4 +: 4] = m_lane[k][l];
        e.valid[k][l]       = m_val[k][l];
      end
      e.sel[k] = 2'(m_pos[k]);
      e.gd[k]  = m_gd[k];
      e.cnt[k] = 8'(m_groups[k] % (1 << p_cw[k]));
      e.ae[k]  = m_ae[k];
    end
  endtask

  task automatic chk(input string name, input int k, input logic [15:0] act,
                     input logic [15:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL step %0d inst %0d %s: got 0x%0h expected 0x%0h",
               step_no, k, name, act, expv);
    end
  endtask

  // Monitor: outputs are registered, so every cycle presents a result.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '0;
      a.data[0] = 16'(d0); a.data[1] = d1; a.data[2] = 16'(d2); a.data[3] = 16'(d3);
      a.valid[0] = 4'(v0); a.valid[1] = v1; a.valid[2] = 4'(v2); a.valid[3] = 4'(v3);
      a.sel[0] = 2'(s0); a.sel[1] = s1; a.sel[2] = s2; a.sel[3] = 2'(s3);
      a.gd = {g3, g2, g1, g0};
      a.cnt[0] = 8'(c0); a.cnt[1] = c1; a.cnt[2] = c2; a.cnt[3] = c3;
      a.ae = {e3, e2, e1, e0};
      for (int k = 0; k < 4; k++) begin
        chk("data_out",   k, a.data[k], e.data[k]);
        chk("valid_out",  k, 16'(a.valid[k]), 16'(e.valid[k]));
        chk("lane_sel",   k, 16'(a.sel[k]), 16'(e.sel[k]));
        chk("group_done", k, 16'(a.gd[k]), 16'(e.gd[k]));
        chk("group_cnt",  k, 16'(a.cnt[k]), 16'(e.cnt[k]));
        chk("align_err",  k, 16'(a.ae[k]), 16'(e.ae[k]));
      end
    end
  end

  // Apply one cycle of stimulus; the expected result is queued once the
  // edge that consumes it has occurred.
  task automatic step(input logic r, input logic v, input logic [3:0] d, input logic a);
    exp_t e;
    rst = r; vin = v; din = d; aln = a;
    model_step(r, v, d, a, e);
    @(posedge clk);
    exp_q.push_back(e);
    step_no++;
    $display("[TB] step %0d reset=%0b valid_in=%0b data_in=0x%0h align=%0b",
             step_no, r, v, d, a);
    #1;
  endtask

  initial begin
    rst = 1'b1; vin = 1'b0; din = 4'h0; aln = 1'b0;
    step(1, 0, 4'h0, 0);
    step(1, 1, 4'hF, 1);   // reset dominates valid_in and align

    // Three back-to-back words
    step(0, 1, 4'hA, 0);
    step(0, 1, 4'hB, 0);
    step(0, 1, 4'hC, 0);
    step(0, 0, 4'h0, 0);
    step(0, 0, 4'h0, 0);

    // Words 1..4 separated by idle cycles
    step(1, 0, 4'h0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 4'(i), 0);
      step(0, 0, 4'h0, 0);
    end

    // Realignment in the middle of a group
    step(1, 0, 4'h0, 0);
    step(0, 1, 4'h1, 0);
    step(0, 1, 4'h2, 0);
    step(0, 1, 4'h3, 1);
    step(0, 0, 4'h0, 0);
    step(0, 0, 4'h0, 1);   // align without a word, pointer not 0
    step(0, 0, 4'h0, 1);   // align again with pointer already 0

    // Reset mid-group
    step(1, 0, 4'h0, 0);
    step(0, 1, 4'h4, 0);
    step(0, 1, 4'h5, 0);
    step(1, 0, 4'h0, 0);
    step(0, 1, 4'h7, 0);
    step(0, 0, 4'h0, 0);

    // Ten words back-to-back (counter wrap on the 2-bit instance)
    step(1, 0, 4'h0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 4'(i + 3), 0);
    step(0, 0, 4'h0, 0);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      logic r, v, a;
      logic [3:0] d;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 9) < 6);
      a = ($urandom_range(0, 7) == 0);
      d = 4'($urandom);
      step(r, v, d, a);
    end
    step(0, 0, 4'h0, 0);

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
